// File: rtl/instruction_decode_hz_if.sv
// ID stage bus: IF/ID inputs, WB and EX/MEM feedback, PC redirect and ID/EX outputs.
interface instruction_decode_hz_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
);
    logic               i_valid;
    logic [NB_DATA-1:0] i_instruction;
    logic [NB_DATA-1:0] i_pcounter4;
    logic               i_stall;
    logic               i_flush;
    logic               i_we_wb;
    logic [NB_ADDR-1:0] i_wr_addr;
    logic [NB_DATA-1:0] i_wr_data_WB;
    logic               i_exmem_we;
    logic               i_exmem_rd;
    logic [NB_ADDR-1:0] i_exmem_addr;
    logic [NB_DATA-1:0] i_exmem_data;

    logic               o_stall_if;
    logic               o_flush_if;
    logic               o_pc_sel;
    logic [NB_DATA-1:0] o_pc_target;
    logic               o_valid;
    logic [NB_DATA-1:0] o_reg_DA;
    logic [NB_DATA-1:0] o_reg_DB;
    logic [NB_DATA-1:0] o_immediate;
    logic [NB_ADDR-1:0] o_rs;
    logic [NB_ADDR-1:0] o_rt;
    logic [NB_ADDR-1:0] o_wr_addr;
    logic [5:0]         o_opcode;
    logic [5:0]         o_func;
    logic [4:0]         o_shamt;
    logic               o_regWrite;
    logic               o_memRead;
    logic               o_memWrite;
    logic               o_mem2Reg;
    logic               o_aluSrc;
    logic               o_link;

    modport slave (
        input  i_valid, i_instruction, i_pcounter4, i_stall, i_flush, i_we_wb, i_wr_addr,
               i_wr_data_WB, i_exmem_we, i_exmem_rd, i_exmem_addr, i_exmem_data,
        output o_stall_if, o_flush_if, o_pc_sel, o_pc_target, o_valid, o_reg_DA, o_reg_DB,
               o_immediate, o_rs, o_rt, o_wr_addr, o_opcode, o_func, o_shamt, o_regWrite,
               o_memRead, o_memWrite, o_mem2Reg, o_aluSrc, o_link
    );

    modport master (
        output i_valid, i_instruction, i_pcounter4, i_stall, i_flush, i_we_wb, i_wr_addr,
               i_wr_data_WB, i_exmem_we, i_exmem_rd, i_exmem_addr, i_exmem_data,
        input  o_stall_if, o_flush_if, o_pc_sel, o_pc_target, o_valid, o_reg_DA, o_reg_DB,
               o_immediate, o_rs, o_rt, o_wr_addr, o_opcode, o_func, o_shamt, o_regWrite,
               o_memRead, o_memWrite, o_mem2Reg, o_aluSrc, o_link
    );
endinterface

// File: rtl/instruction_decode_hz.sv
// MIPS ID stage: write-through register file, decoder, branch/jump resolution with
// EX/MEM forwarding, load-use and branch hazard detection, and the ID/EX register.
module instruction_decode_hz #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int DELAY_SLOT = 0,
    parameter int FWD_EN     = 1
) (
    input logic                    clk,
    input logic                    i_rst,
    instruction_decode_hz_if.slave bus
);
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [NB_DATA-1:0] LINK_INC = (DELAY_SLOT != 0) ? NB_DATA'(4) : '0;

    typedef struct packed {
        logic               valid;
        logic [NB_DATA-1:0] reg_da;
        logic [NB_DATA-1:0] reg_db;
        logic [NB_DATA-1:0] immediate;
        logic [NB_ADDR-1:0] rs;
        logic [NB_ADDR-1:0] rt;
        logic [NB_ADDR-1:0] wr_addr;
        logic [5:0]         opcode;
        logic [5:0]         func;
        logic [4:0]         shamt;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem2reg;
        logic               alu_src;
        logic               link;
    } idex_t;

    idex_t idex_q, idex_d, dec;

    logic [NB_DATA-1:0] regs_q [2**NB_ADDR];

    logic [5:0]         opcode, func;
    logic [NB_ADDR-1:0] rs, rt, rd;
    logic [15:0]        imm;
    logic [NB_DATA-1:0] imm_sext, imm_zext;
    assign opcode   = bus.i_instruction[31:26];
    assign func     = bus.i_instruction[5:0];
    assign rs       = NB_ADDR'(bus.i_instruction[25:21]);
    assign rt       = NB_ADDR'(bus.i_instruction[20:16]);
    assign rd       = NB_ADDR'(bus.i_instruction[15:11]);
    assign imm      = bus.i_instruction[15:0];
    assign imm_sext = {{(NB_DATA-16){imm[15]}}, imm};
    assign imm_zext = NB_DATA'(imm);

    logic is_r, is_jr, is_jalr, is_beq, is_bne, is_j, is_jal, is_load, is_store, is_alui;
    logic uses_rt, cmp_rt, is_brreg;
    assign is_r     = (opcode == 6'b000000);
    assign is_jr    = is_r && (func == FN_JR);
    assign is_jalr  = is_r && (func == FN_JALR);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign is_load  = (opcode[5:3] == 3'b100);
    assign is_store = (opcode[5:3] == 3'b101);
    assign is_alui  = (opcode[5:3] == 3'b001);
    assign cmp_rt   = is_beq || is_bne;
    assign uses_rt  = (is_r && !is_jr && !is_jalr) || cmp_rt || is_store;
    // Instructions whose register operands are consumed here, in ID
    assign is_brreg = cmp_rt || is_jr || is_jalr;

    // Register file; r0 is never written so it always reads zero
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2**NB_ADDR; i++) regs_q[i] <= '0;
        end else if (bus.i_we_wb && bus.i_wr_addr != '0) begin
            regs_q[bus.i_wr_addr] <= bus.i_wr_data_WB;
        end
    end

    // Write-through reads: a same-cycle WB write wins over the stored value
    logic [NB_DATA-1:0] rs_val, rt_val;
    always_comb begin
        rs_val = regs_q[rs];
        rt_val = regs_q[rt];
        if (bus.i_we_wb && bus.i_wr_addr != '0 && bus.i_wr_addr == rs) rs_val = bus.i_wr_data_WB;
        if (bus.i_we_wb && bus.i_wr_addr != '0 && bus.i_wr_addr == rt) rt_val = bus.i_wr_data_WB;
    end

    // Hazard detection and EX/MEM forwarding for the branch comparator / JR target
    logic exm_rs, exm_rt, idex_rs, idex_rt, load_use, br_hz, hazard;
    logic [NB_DATA-1:0] br_rs, br_rt;
    always_comb begin
        exm_rs   = bus.i_exmem_we && bus.i_exmem_addr != '0 && bus.i_exmem_addr == rs;
        exm_rt   = bus.i_exmem_we && bus.i_exmem_addr != '0 && bus.i_exmem_addr == rt;
        idex_rs  = idex_q.valid && idex_q.reg_write && idex_q.wr_addr != '0 &&
                   idex_q.wr_addr == rs;
        idex_rt  = idex_q.valid && idex_q.reg_write && idex_q.wr_addr != '0 &&
                   idex_q.wr_addr == rt;
        load_use = idex_q.valid && idex_q.mem_read && idex_q.wr_addr != '0 &&
                   (idex_q.wr_addr == rs || (uses_rt && idex_q.wr_addr == rt));
        br_hz    = is_brreg && (idex_rs || (cmp_rt && idex_rt) ||
                   ((exm_rs || (cmp_rt && exm_rt)) && (bus.i_exmem_rd || (FWD_EN == 0))));
        hazard   = bus.i_valid && (load_use || br_hz);
        br_rs    = exm_rs ? bus.i_exmem_data : rs_val;
        br_rt    = exm_rt ? bus.i_exmem_data : rt_val;
    end

    // Redirect decision and target selection
    logic taken;
    logic [NB_DATA-1:0] target;
    always_comb begin
        taken = bus.i_valid && !hazard && !bus.i_stall && !bus.i_flush &&
                ((is_beq && br_rs == br_rt) || (is_bne && br_rs != br_rt) ||
                 is_j || is_jal || is_jr || is_jalr);
        if (is_jr || is_jalr) begin
            target = br_rs;
        end else if (is_j || is_jal) begin
            target = {bus.i_pcounter4[NB_DATA-1:28], bus.i_instruction[25:0], 2'b00};
        end else begin
            target = bus.i_pcounter4 + (imm_sext << 2);
        end
    end

    // Control decode of the instruction currently in IF/ID
    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.rs        = rs;
        dec.rt        = rt;
        dec.opcode    = opcode;
        dec.func      = func;
        dec.shamt     = bus.i_instruction[10:6];
        dec.immediate = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) ?
                        imm_zext : imm_sext;
        dec.reg_da    = rs_val;
        dec.reg_db    = rt_val;
        dec.reg_write = (is_r && !is_jr) || is_jal || is_load || is_alui;
        dec.mem_read  = is_load;
        dec.mem_write = is_store;
        dec.mem2reg   = is_load;
        dec.alu_src   = is_load || is_store || is_alui;
        dec.link      = is_jal || is_jalr;
        if (is_jal)                    dec.wr_addr = '1;
        else if (is_r && !is_jr)       dec.wr_addr = rd;
        else if (is_load || is_alui)   dec.wr_addr = rt;
        if (dec.link) begin
            dec.reg_da = bus.i_pcounter4 + LINK_INC;
            dec.reg_db = '0;
        end
    end

    // ID/EX next state: hold on stall, bubble on hazard/flush/empty slot
    always_comb begin
        idex_d = idex_q;
        if (!bus.i_stall) begin
            if (hazard || bus.i_flush || !bus.i_valid) idex_d = '0;
            else                                        idex_d = dec;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    // Combinational outputs are forced low while reset is asserted
    assign bus.o_stall_if  = (hazard || bus.i_stall) && !i_rst;
    assign bus.o_pc_sel    = taken && !i_rst;
    assign bus.o_flush_if  = taken && (DELAY_SLOT == 0) && !i_rst;
    assign bus.o_pc_target = i_rst ? '0 : target;

    assign bus.o_valid     = idex_q.valid;
    assign bus.o_reg_DA    = idex_q.reg_da;
    assign bus.o_reg_DB    = idex_q.reg_db;
    assign bus.o_immediate = idex_q.immediate;
    assign bus.o_rs        = idex_q.rs;
    assign bus.o_rt        = idex_q.rt;
    assign bus.o_wr_addr   = idex_q.wr_addr;
    assign bus.o_opcode    = idex_q.opcode;
    assign bus.o_func      = idex_q.func;
    assign bus.o_shamt     = idex_q.shamt;
    assign bus.o_regWrite  = idex_q.reg_write;
    assign bus.o_memRead   = idex_q.mem_read;
    assign bus.o_memWrite  = idex_q.mem_write;
    assign bus.o_mem2Reg   = idex_q.mem2reg;
    assign bus.o_aluSrc    = idex_q.alu_src;
    assign bus.o_link      = idex_q.link;
endmodule

// File: tb/tb_instruction_decode_hz.sv
// Bench for instruction_decode_hz: two instances (delay slot off/on) share stimulus;
// ID/EX expectations go through a scoreboard queue, redirect/stall checked same-cycle.
module tb_instruction_decode_hz;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_decode_hz_if #(.NB_DATA(32), .NB_ADDR(5)) bus0 ();
    instruction_decode_hz_if #(.NB_DATA(32), .NB_ADDR(5)) bus1 ();

    instruction_decode_hz #(.NB_DATA(32), .NB_ADDR(5), .DELAY_SLOT(0), .FWD_EN(1)) dut0 (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus0)
    );
    instruction_decode_hz #(.NB_DATA(32), .NB_ADDR(5), .DELAY_SLOT(1), .FWD_EN(1)) dut1 (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    assign bus1.i_valid       = bus0.i_valid;
    assign bus1.i_instruction = bus0.i_instruction;
    assign bus1.i_pcounter4   = bus0.i_pcounter4;
    assign bus1.i_stall       = bus0.i_stall;
    assign bus1.i_flush       = bus0.i_flush;
    assign bus1.i_we_wb       = bus0.i_we_wb;
    assign bus1.i_wr_addr     = bus0.i_wr_addr;
    assign bus1.i_wr_data_WB  = bus0.i_wr_data_WB;
    assign bus1.i_exmem_we    = bus0.i_exmem_we;
    assign bus1.i_exmem_rd    = bus0.i_exmem_rd;
    assign bus1.i_exmem_addr  = bus0.i_exmem_addr;
    assign bus1.i_exmem_data  = bus0.i_exmem_data;

    typedef struct packed {
        logic        valid;
        logic [31:0] da;
        logic [31:0] db;
        logic [31:0] imm;
        logic [4:0]  wr;
        logic [5:0]  ctrl;  // {regWrite, memRead, memWrite, mem2Reg, aluSrc, link}
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] da,
                                input logic [31:0] db, input logic [4:0] wr,
                                input logic [5:0] ctrl, input logic zext);
        exp_t e;
        e.valid = 1'b1;
        e.da    = da;
        e.db    = db;
        e.imm   = zext ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        e.wr    = wr;
        e.ctrl  = ctrl;
        return e;
    endfunction

    // One cycle: inputs already driven at the negedge; check redirect/stall, then ID/EX
    task automatic step(input string tag, input exp_t e, input logic x_stall,
                        input logic x_sel, input logic [31:0] x_target);
        exp_t got_e;
        #1;
        check_eq({tag, "_stall_if"}, 64'(bus0.o_stall_if), 64'(x_stall));
        check_eq({tag, "_pc_sel"}, 64'(bus0.o_pc_sel), 64'(x_sel));
        check_eq({tag, "_flush_if"}, 64'(bus0.o_flush_if), 64'(x_sel));
        check_eq({tag, "_pc_sel_ds1"}, 64'(bus1.o_pc_sel), 64'(x_sel));
        check_eq({tag, "_flush_if_ds1"}, 64'(bus1.o_flush_if), 64'(0));
        if (x_sel) check_eq({tag, "_target"}, 64'(bus0.o_pc_target), 64'(x_target));
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got_e = sb_q.pop_front();
        check_eq({tag, "_valid"}, 64'(bus0.o_valid), 64'(got_e.valid));
        check_eq({tag, "_DA"}, 64'(bus0.o_reg_DA), 64'(got_e.da));
        check_eq({tag, "_DB"}, 64'(bus0.o_reg_DB), 64'(got_e.db));
        check_eq({tag, "_imm"}, 64'(bus0.o_immediate), 64'(got_e.imm));
        check_eq({tag, "_wr_addr"}, 64'(bus0.o_wr_addr), 64'(got_e.wr));
        check_eq({tag, "_ctrl"}, 64'({bus0.o_regWrite, bus0.o_memRead, bus0.o_memWrite,
                 bus0.o_mem2Reg, bus0.o_aluSrc, bus0.o_link}), 64'(got_e.ctrl));
        check_eq({tag, "_valid_ds1"}, 64'(bus1.o_valid), 64'(got_e.valid));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(bus0.o_valid), 64'(0));
        check_eq({tag, "_DA"}, 64'(bus0.o_reg_DA), 64'(0));
        check_eq({tag, "_ctrl"}, 64'({bus0.o_regWrite, bus0.o_memRead, bus0.o_link}), 64'(0));
        check_eq({tag, "_stall_if"}, 64'(bus0.o_stall_if), 64'(0));
        check_eq({tag, "_pc_sel"}, 64'(bus0.o_pc_sel), 64'(0));
        check_eq({tag, "_wr_addr"}, 64'(bus0.o_wr_addr), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        exp_t        e_add;
        logic [4:0]  pre_a [3];
        pre_a = '{5'd1, 5'd2, 5'd7};

        rst = 1'b1;
        bus0.i_valid = 0; bus0.i_instruction = '0; bus0.i_pcounter4 = '0;
        bus0.i_stall = 0; bus0.i_flush = 0; bus0.i_we_wb = 0; bus0.i_wr_addr = '0;
        bus0.i_wr_data_WB = '0; bus0.i_exmem_we = 0; bus0.i_exmem_rd = 0;
        bus0.i_exmem_addr = '0; bus0.i_exmem_data = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Preload r1, r2, r7 = 0x11 through WB while IF/ID is empty
        foreach (pre_a[i]) begin
            bus0.i_we_wb = 1; bus0.i_wr_addr = pre_a[i]; bus0.i_wr_data_WB = 32'h11;
            step("preload", exp_t'(0), 0, 0, 0);
        end

        // ADD r6,r5,r1 with same-cycle WB of r5
        bus0.i_wr_addr = 5; bus0.i_wr_data_WB = 32'h1234;
        ins = r_ins(5, 1, 6, 6'h20);
        bus0.i_valid = 1; bus0.i_instruction = ins; bus0.i_pcounter4 = 32'h10;
        e_add = mk(ins, 32'h1234, 32'h11, 6, 6'b100000, 0);
        step("add_bypass", e_add, 0, 0, 0);
        bus0.i_we_wb = 0;

        // LW r3,4(r1) then dependent ADD r4,r3,r1
        ins = i_ins(6'b100011, 1, 3, 16'd4); bus0.i_instruction = ins;
        step("lw", mk(ins, 32'h11, 32'h0, 3, 6'b110110, 0), 0, 0, 0);
        ins = r_ins(3, 1, 4, 6'h20); bus0.i_instruction = ins;
        step("load_use", exp_t'(0), 1, 0, 0);
        bus0.i_we_wb = 1; bus0.i_wr_addr = 3; bus0.i_wr_data_WB = 32'h77;
        step("add_after_lu", mk(ins, 32'h77, 32'h11, 4, 6'b100000, 0), 0, 0, 0);
        bus0.i_we_wb = 0;

        // BEQ r1,r2,+3 at pc4=0x100, equal operands
        ins = i_ins(6'b000100, 1, 2, 16'd3);
        bus0.i_instruction = ins; bus0.i_pcounter4 = 32'h100;
        step("beq", mk(ins, 32'h11, 32'h11, 0, 6'b000000, 0), 0, 1, 32'h10C);

        // JAL 0x40 at pc4=0x204
        ins = {6'b000011, 26'h40};
        bus0.i_instruction = ins; bus0.i_pcounter4 = 32'h204;
        step("jal", mk(ins, 32'h204, 32'h0, 31, 6'b100001, 0), 0, 1, 32'h100);
        check_eq("jal_link_ds1", 64'(bus1.o_reg_DA), 64'(32'h208));
        check_eq("jal_wr_addr_ds1", 64'(bus1.o_wr_addr), 64'(31));

        // BNE r7,r2,-2: r7 forwarded from EX/MEM ALU result (0x55 != 0x11)
        ins = i_ins(6'b000101, 7, 2, 16'hFFFE);
        bus0.i_instruction = ins; bus0.i_pcounter4 = 32'h300;
        bus0.i_exmem_we = 1; bus0.i_exmem_addr = 7; bus0.i_exmem_data = 32'h55;
        step("bne_fwd", mk(ins, 32'h11, 32'h11, 0, 6'b000000, 0), 0, 1, 32'h2F8);
        // Same BNE while EX/MEM holds a load of r7 -> one stall
        bus0.i_exmem_rd = 1;
        step("bne_exm_load", exp_t'(0), 1, 0, 0);
        bus0.i_exmem_we = 0; bus0.i_exmem_rd = 0;
        bus0.i_we_wb = 1; bus0.i_wr_addr = 7; bus0.i_wr_data_WB = 32'h55;
        step("bne_after", mk(ins, 32'h55, 32'h11, 0, 6'b000000, 0), 0, 1, 32'h2F8);
        bus0.i_we_wb = 0;

        // Immediate extension and store decode
        ins = i_ins(6'b001100, 1, 8, 16'h8000);
        bus0.i_instruction = ins; bus0.i_pcounter4 = 32'h400;
        step("andi_zext", mk(ins, 32'h11, 32'h0, 8, 6'b100010, 1), 0, 0, 0);
        ins = i_ins(6'b001000, 1, 9, 16'h8000); bus0.i_instruction = ins;
        step("addi_sext", mk(ins, 32'h11, 32'h0, 9, 6'b100010, 0), 0, 0, 0);
        ins = i_ins(6'b101011, 1, 2, 16'd8); bus0.i_instruction = ins;
        step("sw", mk(ins, 32'h11, 32'h11, 0, 6'b001010, 0), 0, 0, 0);

        // External stall for 3 cycles: ID/EX frozen, no redirect for a taken BEQ
        bus0.i_instruction = r_ins(5, 1, 6, 6'h20);
        step("add_pre_stall", e_add, 0, 0, 0);
        bus0.i_stall = 1;
        bus0.i_instruction = i_ins(6'b000100, 1, 2, 16'd3); bus0.i_pcounter4 = 32'h100;
        repeat (3) step("ext_stall", e_add, 1, 0, 0);
        bus0.i_stall = 0;

        // External flush
        bus0.i_flush = 1; bus0.i_instruction = r_ins(5, 1, 6, 6'h20);
        step("ext_flush", exp_t'(0), 0, 0, 0);
        bus0.i_flush = 0;

        // Reset asserted mid-stall clears everything, including the register file
        step("add_pre_rst", e_add, 0, 0, 0);
        bus0.i_stall = 1;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_held");
        rst = 1'b0; bus0.i_stall = 0;
        ins = r_ins(5, 1, 6, 6'h20); bus0.i_instruction = ins;
        step("add_post_rst", mk(ins, 32'h0, 32'h0, 6, 6'b100000, 0), 0, 0, 0);
        bus0.i_valid = 0;
        step("idle", exp_t'(0), 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
